// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
// Module      : mdu
// Description : Iterative multiply/divide unit beside the ALU. Owns the
//               architectural HI/LO registers. Shift-add multiply and
//               restoring divide, one bit per cycle on operand magnitudes,
//               with sign fixup in a final cycle. mthi/mtlo write HI/LO
//               directly from operand a.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int               c_CNT_W = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH);

    localparam logic [OP_W-1:0] c_OP_MULT  = OP_W'(0);
    localparam logic [OP_W-1:0] c_OP_MULTU = OP_W'(1);
    localparam logic [OP_W-1:0] c_OP_DIV   = OP_W'(2);
    localparam logic [OP_W-1:0] c_OP_DIVU  = OP_W'(3);
    localparam logic [OP_W-1:0] c_OP_MTHI  = OP_W'(4);
    localparam logic [OP_W-1:0] c_OP_MTLO  = OP_W'(5);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2*WIDTH-1:0] r_p;        // {upper, lower} working register
    logic [WIDTH-1:0]   r_opnd;     // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   r_raw_a;    // raw dividend for the divide-by-zero result
    logic               r_is_div;
    logic               r_div_zero;
    logic               r_neg_q;    // negate product / quotient
    logic               r_neg_r;    // negate remainder
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_accept;
    logic               w_iter_op;
    logic               w_signed_op;
    logic               w_div_op;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_madd;
    logic [WIDTH:0]     w_dup;
    logic               w_dge;
    logic [WIDTH-1:0]   w_dsub;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_accept    = (r_state == c_IDLE) && start;
    assign w_signed_op = (op == c_OP_MULT) || (op == c_OP_DIV);
    assign w_div_op    = (op == c_OP_DIV)  || (op == c_OP_DIVU);
    assign w_iter_op   = w_div_op || (op == c_OP_MULT) || (op == c_OP_MULTU);

    assign w_mag_a = (w_signed_op && a[WIDTH-1]) ? -a : a;
    assign w_mag_b = (w_signed_op && b[WIDTH-1]) ? -b : b;

    // Multiply step: add multiplicand into the upper half when the LSB of the
    // multiplier is set, then shift the whole register right with the carry.
    assign w_madd = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_opnd} : '0);

    // Restoring divide step: shift left one bit and subtract the divisor from
    // the partial remainder when it fits; the fit decision is the quotient bit.
    assign w_dup  = r_p[2*WIDTH-1:WIDTH-1];
    assign w_dge  = w_dup >= {1'b0, r_opnd};
    assign w_dsub = w_dup[WIDTH-1:0] - r_opnd;

    // Sign fixup of the magnitude results.
    assign w_prod = r_neg_q ? -r_p : r_p;
    assign w_quo  = r_neg_q ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0];
    assign w_rem  = r_neg_r ? -r_p[2*WIDTH-1:WIDTH] : r_p[2*WIDTH-1:WIDTH];

    // The first RUN cycle (count 0) is an issue slot, so busy rises one edge
    // after acceptance and stays high through FIX.
    assign busy = ((r_state == c_RUN) && (r_cnt != '0)) || (r_state == c_FIX);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: if (start && w_iter_op) w_state_nxt = c_RUN;
            c_RUN:  if (r_cnt == c_LAST)    w_state_nxt = c_FIX;
            c_FIX:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Operand capture, iteration datapath, and HI/LO writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_p        <= '0;
            r_opnd     <= '0;
            r_raw_a    <= '0;
            r_is_div   <= 1'b0;
            r_div_zero <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_accept && w_iter_op) begin
                        r_cnt      <= '0;
                        r_raw_a    <= a;
                        r_is_div   <= w_div_op;
                        r_div_zero <= w_div_op && (b == '0);
                        r_neg_q    <= w_signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_neg_r    <= w_signed_op && w_div_op && a[WIDTH-1];
                        if (w_div_op) begin
                            r_p    <= {{WIDTH{1'b0}}, w_mag_a};
                            r_opnd <= w_mag_b;
                        end else begin
                            r_p    <= {{WIDTH{1'b0}}, w_mag_b};
                            r_opnd <= w_mag_a;
                        end
                    end else if (w_accept && (op == c_OP_MTHI)) begin
                        r_hi <= a;
                    end else if (w_accept && (op == c_OP_MTLO)) begin
                        r_lo <= a;
                    end
                end
                c_RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt != '0) begin
                        if (r_is_div) begin
                            r_p <= {(w_dge ? w_dsub : w_dup[WIDTH-1:0]), r_p[WIDTH-2:0], w_dge};
                        end else begin
                            r_p <= {w_madd, r_p[WIDTH-1:1]};
                        end
                    end
                end
                c_FIX: begin
                    r_done <= 1'b1;
                    if (!r_is_div) begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end else if (r_div_zero) begin
                        r_hi <= r_raw_a;
                        r_lo <= '1;
                    end else begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu
// Description : Self-checking bench for mdu. Directed and random operations
//               compared against an arithmetic reference model, including
//               latency, busy window, ignored starts, and mid-run reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_checks;
    int          n_errors;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu #(.WIDTH(32), .OP_W(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: {hi, lo} straight from integer arithmetic.
    function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] x,
                                              input logic [31:0] y);
        longint sp;
        int     sx;
        int     sy;
        case (o)
            3'd0: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                return sp;
            end
            3'd1: return {32'b0, x} * {32'b0, y};
            3'd2: begin
                if (y == 32'd0) return {x, 32'hFFFFFFFF};
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                sx = x;
                sy = y;
                return {32'(sx % sy), 32'(sx / sy)};
            end
            3'd3: begin
                if (y == 32'd0) return {x, 32'hFFFFFFFF};
                return {x % y, x / y};
            end
            default: return 64'd0;
        endcase
    endfunction

    // One iterative op: checks busy window, held HI/LO, done timing and result.
    // poke_cyc: edge index at which a stray mult start is driven (0 = none).
    // rst_cyc: edge index at which reset aborts the op (0 = none).
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int poke_cyc, input int rst_cyc, input bit start_on_done);
        logic [63:0] exp;
        logic [31:0] h0;
        logic [31:0] l0;
        exp = ref_model(o, x, y);
        h0  = m_hi;
        l0  = m_lo;
        start = 1'b1; op = o; a = x; b = y;
        tick();
        start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
        chk("busy_issue", busy, 1'b0);
        chk("done_issue", done, 1'b0);
        for (int i = 1; i <= 33; i++) begin
            if (i == poke_cyc) begin
                start = 1'b1; op = 3'd0; a = $urandom; b = $urandom;
            end
            if (i == rst_cyc) rst = 1'b1;
            tick();
            start = 1'b0;
            if (i == rst_cyc) begin
                rst = 1'b0;
                m_hi = 32'd0;
                m_lo = 32'd0;
                chk("abort_busy", busy, 1'b0);
                chk("abort_done", done, 1'b0);
                chk("abort_hi", hi, 32'd0);
                chk("abort_lo", lo, 32'd0);
                repeat (36) begin
                    tick();
                    chk("abort_nodone", done, 1'b0);
                    chk("abort_idle", busy, 1'b0);
                end
                return;
            end
            chk("busy_run", busy, 1'b1);
            chk("done_run", done, 1'b0);
            chk("hi_held", hi, h0);
            chk("lo_held", lo, l0);
        end
        if (start_on_done) begin
            start = 1'b1; op = 3'd4; a = ~exp[63:32];
        end
        tick();
        start = 1'b0;
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        chk("done_pulse", done, 1'b1);
        chk("busy_end", busy, 1'b0);
        chk("hi_result", hi, m_hi);
        chk("lo_result", lo, m_lo);
        tick();
        chk("done_clear", done, 1'b0);
        chk("busy_idle", busy, 1'b0);
        chk("hi_after", hi, m_hi);
        chk("lo_after", lo, m_lo);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  ro;
        n_checks = 0;
        n_errors = 0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        rst = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        repeat (3) tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);

        // Reset outranks start, both for a move and for an iterative op.
        start = 1'b1; op = 3'd4; a = 32'hDEADBEEF;
        tick();
        chk("rst_wins_mthi", hi, 32'd0);
        op = 3'd3; a = 32'd9; b = 32'd3;
        tick();
        rst = 1'b0; start = 1'b0;
        tick();
        chk("rst_wins_busy", busy, 1'b0);
        tick();
        chk("rst_wins_busy2", busy, 1'b0);
        chk("rst_wins_done", done, 1'b0);

        // Directed operations.
        run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1'b0);
        run_op(3'd0, 32'hFFFFFFFD, 32'd5, 0, 0, 1'b0);
        run_op(3'd2, 32'hFFFFFFF9, 32'd2, 0, 0, 1'b0);
        run_op(3'd3, 32'd7, 32'd0, 0, 0, 1'b0);
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0, 1'b0);

        // Moves on consecutive cycles, then reserved ops.
        start = 1'b1; op = 3'd4; a = 32'h12345678;
        tick();
        m_hi = 32'h12345678;
        chk("mthi_hi", hi, m_hi);
        chk("mthi_busy", busy, 1'b0);
        chk("mthi_done", done, 1'b0);
        op = 3'd5; a = 32'h9ABCDEF0;
        tick();
        m_lo = 32'h9ABCDEF0;
        chk("mtlo_lo", lo, m_lo);
        chk("mtlo_hi", hi, m_hi);
        chk("mtlo_busy", busy, 1'b0);
        chk("mtlo_done", done, 1'b0);
        op = 3'd6; a = 32'h0BADF00D;
        tick();
        op = 3'd7;
        tick();
        start = 1'b0;
        chk("rsv_hi", hi, m_hi);
        chk("rsv_lo", lo, m_lo);
        chk("rsv_busy", busy, 1'b0);
        tick();
        chk("rsv_busy2", busy, 1'b0);

        // Start while busy ignored; start on the done edge ignored.
        run_op(3'd3, 32'd100, 32'd7, 5, 0, 1'b1);
        // Reset mid-multiply, then a fresh divide.
        run_op(3'd0, 32'h00012345, 32'h00000777, 0, 10, 1'b0);
        run_op(3'd3, 32'd9, 32'd3, 0, 0, 1'b0);

        // Random operations.
        for (int k = 0; k < 16; k++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                3: rb = -32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op(ro, ra, rb, (k % 3 == 0) ? int'($urandom_range(1, 33)) : 0, 0, k[0]);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
